md_alu_control: RTL and testbench



---
 rtl/md_alu_control.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_md_alu_control.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/md_alu_control.sv
// -----------------------------------------------------------------------------
// md_alu_control
//
// Execute-stage ALU control plus an iterative signed multiply/divide sequencer.
// The instruction in the D/X latch is decoded combinationally into the ALU
// operation, shift amount and immediate-operand select. Multiply and divide
// instructions are run one bit per cycle (shift-add / restoring shift-subtract)
// on operand magnitudes. The sign is applied when the result is presented.
// While the sequencer is busy it stalls the front of the pipeline.
//
// Optional feature macro: MD_ZERO_BYPASS_EN
//   When defined, a multiply with a zero operand, or a divide with a zero
//   dividend and a nonzero divisor, skips the iteration and finishes in one
//   stall cycle. Divide-by-zero always finishes in one stall cycle.
//
// Parameters
//   WIDTH         operand/result width in bits (>= 4)
//   CNTW          iteration counter width
//
// Ports
//   clock         pipeline clock, rising edge
//   reset         asynchronous, active-high reset
//   dx_ir         D/X instruction: opcode [31:27], shamt [11:7], ALU op [6:2]
//   operand_a     rs value (multiplicand / dividend)
//   operand_b     rt value (multiplier / divisor)
//   alu_op        ALU operation select
//   shamt         shift amount
//   sx_sel        immediate-operand select
//   md_stall      hold PC, F/D and D/X; bubble into X/M
//   md_valid      one-cycle pulse, md_result valid this cycle
//   md_result     product low word or quotient (held until the next result)
//   md_exception  overflow or divide-by-zero, qualified by md_valid
// -----------------------------------------------------------------------------
module md_alu_control #(
  parameter int WIDTH = 32,
  parameter int CNTW  = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [31:0]      dx_ir,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic [4:0]       alu_op,
  output logic [4:0]       shamt,
  output logic             sx_sel,
  output logic             md_stall,
  output logic             md_valid,
  output logic [WIDTH-1:0] md_result,
  output logic             md_exception
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

  localparam logic [4:0] OP_MULT = 5'd6;
  localparam logic [4:0] OP_DIV  = 5'd7;

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  logic [4:0] ir_opcode;
  logic [4:0] ir_op;
  logic [4:0] ir_shamt;
  logic       is_md;
  logic       is_div_ir;

  assign ir_opcode = dx_ir[31:27];
  assign ir_op     = dx_ir[6:2];
  assign ir_shamt  = dx_ir[11:7];

  // Fields this block does not decode.
  logic unused_ir_bits;
  assign unused_ir_bits = ^{dx_ir[26:12], dx_ir[1:0]};

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    is_md     = 1'b0;
    is_div_ir = 1'b0;
    alu_op    = 5'd0;
    shamt     = 5'd0;
    sx_sel    = 1'b1;

    if (ir_opcode == 5'd0) begin
      is_md     = (ir_op == OP_MULT) || (ir_op == OP_DIV);
      is_div_ir = (ir_op == OP_DIV);
      shamt     = ir_shamt;
      sx_sel    = 1'b0;
      if (!is_md) begin
        alu_op = ir_op;
      end
    end else if ((ir_opcode == 5'd2) || (ir_opcode == 5'd6)) begin
      alu_op = 5'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer state
  //   acc_q   mult: {partial product high, remaining multiplier bits}
  //           div : {partial remainder, dividend bits / quotient bits}
  //   opd_q   multiplicand magnitude (mult) or divisor magnitude (div)
  // ---------------------------------------------------------------------------
  state_e             state_q,  state_d;
  logic [CNTW-1:0]    count_q,  count_d;
  logic [2*WIDTH-1:0] acc_q,    acc_d;
  logic [WIDTH-1:0]   opd_q,    opd_d;
  logic               neg_q,    neg_d;
  logic               div_q,    div_d;
  logic               dz_q,     dz_d;
  logic [WIDTH-1:0]   result_q, result_d;

  // Operand magnitudes; |MIN| = 2^(WIDTH-1) still fits as an unsigned value.
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             a_zero;
  logic             b_zero;
  logic             zero_bypass;

  assign a_mag  = operand_a[WIDTH-1] ? (~operand_a + 1'b1) : operand_a;
  assign b_mag  = operand_b[WIDTH-1] ? (~operand_b + 1'b1) : operand_b;
  assign a_zero = (operand_a == '0);
  assign b_zero = (operand_b == '0);

`ifdef MD_ZERO_BYPASS_EN
  // Trivially-zero results skip the iteration entirely.
  assign zero_bypass = is_div_ir ? a_zero : (a_zero || b_zero);
`else
  assign zero_bypass = 1'b0;
`endif

  // One multiply iteration: conditionally add the multiplicand into the upper
  // half, then shift the whole accumulator right (carry enters at the top).
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;

  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                  + (acc_q[0] ? {1'b0, opd_q} : {(WIDTH + 1){1'b0}});
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // One restoring divide iteration: shift the next dividend bit into the
  // remainder, trial-subtract the divisor, keep the difference if it did not
  // borrow. The remainder stays below the divisor, so bit WIDTH of the shifted
  // value is always zero and the borrow shows up in diff bit WIDTH.
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] div_next;

  assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opd_q};
  assign div_next  = div_diff[WIDTH]
                   ? {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                   : {div_diff[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b1};

  // ---------------------------------------------------------------------------
  // Result formation (used in DONE)
  // ---------------------------------------------------------------------------
  logic [2*WIDTH-1:0] prod_signed;
  logic [WIDTH-1:0]   quo_mag;
  logic [WIDTH-1:0]   done_result;
  logic               done_exc;
  logic [WIDTH:0]     prod_top;

  assign prod_signed = neg_q ? (~acc_q + 1'b1) : acc_q;
  assign prod_top    = prod_signed[2*WIDTH-1:WIDTH-1];
  assign quo_mag     = acc_q[WIDTH-1:0];

  always_comb begin
    done_result = '0;
    done_exc    = 1'b0;
    if (div_q) begin
      done_result = neg_q ? (~quo_mag + 1'b1) : quo_mag;
      // A positive quotient with the top bit set only arises from MIN / -1.
      done_exc    = !neg_q && quo_mag[WIDTH-1];
    end else begin
      done_result = prod_signed[WIDTH-1:0];
      // Overflow when the product does not sign-extend from bit WIDTH-1.
      done_exc    = !((&prod_top) || (~|prod_top));
    end
    // Divide-by-zero leaves the accumulator cleared, so the result is zero.
    if (dz_q) begin
      done_exc = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    acc_d    = acc_q;
    opd_d    = opd_q;
    neg_d    = neg_q;
    div_d    = div_q;
    dz_d     = dz_q;
    result_d = result_q;

    unique case (state_q)
      ST_IDLE: begin
        if (is_md) begin
          count_d = '0;
          div_d   = is_div_ir;
          neg_d   = operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
          dz_d    = 1'b0;
          if (is_div_ir) begin
            acc_d = {{WIDTH{1'b0}}, a_mag};
            opd_d = b_mag;
          end else begin
            acc_d = {{WIDTH{1'b0}}, b_mag};
            opd_d = a_mag;
          end
          if (is_div_ir && b_zero) begin
            acc_d   = '0;
            dz_d    = 1'b1;
            state_d = ST_DONE;
          end else if (zero_bypass) begin
            acc_d   = '0;
            state_d = ST_DONE;
          end else begin
            state_d = ST_RUN;
          end
        end
      end

      ST_RUN: begin
        acc_d   = div_q ? div_next : mul_next;
        count_d = count_q + CNTW'(1);
        if (count_q == CNTW'(WIDTH - 1)) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        result_d = done_result;
        state_d  = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: the datapath registers are reset along with the FSM because the
  // held md_result is architecturally visible and must read zero after reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      state_q  <= ST_IDLE;
      count_q  <= '0;
      acc_q    <= '0;
      opd_q    <= '0;
      neg_q    <= 1'b0;
      div_q    <= 1'b0;
      dz_q     <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      acc_q    <= acc_d;
      opd_q    <= opd_d;
      neg_q    <= neg_d;
      div_q    <= div_d;
      dz_q     <= dz_d;
      result_q <= result_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // md_stall is gated by reset so it drops as soon as reset asserts, even
  // while a mult/div instruction is still sitting in D/X.
  assign md_stall     = !reset
                      && (((state_q == ST_IDLE) && is_md) || (state_q == ST_RUN));
  assign md_valid     = (state_q == ST_DONE);
  assign md_exception = (state_q == ST_DONE) && done_exc;
  assign md_result    = (state_q == ST_DONE) ? done_result : result_q;

endmodule

// File: tb/tb_md_alu_control.sv
module tb_md_alu_control;

  localparam int W = 32;

  logic          clock;
  logic          reset;
  logic [31:0]   dx_ir;
  logic [W-1:0]  operand_a;
  logic [W-1:0]  operand_b;
  logic [4:0]    alu_op;
  logic [4:0]    shamt;
  logic          sx_sel;
  logic          md_stall;
  logic          md_valid;
  logic [W-1:0]  md_result;
  logic          md_exception;

  int n_cmp = 0;
  int n_err = 0;

  md_alu_control #(.WIDTH(W)) dut (
    .clock        (clock),
    .reset        (reset),
    .dx_ir        (dx_ir),
    .operand_a    (operand_a),
    .operand_b    (operand_b),
    .alu_op       (alu_op),
    .shamt        (shamt),
    .sx_sel       (sx_sel),
    .md_stall     (md_stall),
    .md_valid     (md_valid),
    .md_result    (md_result),
    .md_exception (md_exception)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] observed,
                       input logic [63:0] expected);
    n_cmp++;
    assert (observed === expected) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] mk_ir(input logic [4:0] opc,
                                        input logic [4:0] op,
                                        input logic [4:0] sh);
    logic [31:0] r;
    r        = $urandom;
    r[31:27] = opc;
    r[11:7]  = sh;
    r[6:2]   = op;
    return r;
  endfunction

  // Reference model: plain 64-bit signed arithmetic.
  function automatic void ref_md(input bit is_div, input logic [31:0] a,
                                 input logic [31:0] b,
                                 output logic [31:0] res, output logic exc,
                                 output int stalls);
    longint sa;
    longint sb;
    longint p;
    longint q;
    sa     = longint'($signed(a));
    sb     = longint'($signed(b));
    stalls = W + 1;
    res    = '0;
    exc    = 1'b0;
    if (!is_div) begin
      p   = sa * sb;
      res = p[31:0];
      exc = (p > 64'sd2147483647) || (p < -64'sd2147483648);
`ifdef MD_ZERO_BYPASS_EN
      if (sa == 0 || sb == 0) stalls = 1;
`endif
    end else if (sb == 0) begin
      res    = '0;
      exc    = 1'b1;
      stalls = 1;
    end else begin
      q = sa / sb;
      if (q > 64'sd2147483647) begin
        res = 32'h8000_0000;
        exc = 1'b1;
      end else begin
        res = q[31:0];
      end
`ifdef MD_ZERO_BYPASS_EN
      if (sa == 0) stalls = 1;
`endif
    end
  endfunction

  // Entered just after a falling edge. Issues one mult/div, counts stall
  // cycles until md_valid, checks the result, then the pipeline advances.
  task automatic run_md(input bit is_div, input logic [31:0] a,
                        input logic [31:0] b, input string tag);
    logic [31:0] exp_res;
    logic        exp_exc;
    int          exp_stalls;
    int          stalls;
    bit          got;
    ref_md(is_div, a, b, exp_res, exp_exc, exp_stalls);
    dx_ir     = mk_ir(5'd0, is_div ? 5'd7 : 5'd6, 5'($urandom));
    operand_a = a;
    operand_b = b;
    stalls    = 0;
    got       = 1'b0;
    #1;
    for (int c = 0; c < 200 && !got; c++) begin
      if (md_valid) begin
        got = 1'b1;
      end else begin
        if (md_stall) stalls++;
        if (stalls == 2) begin
          // Operands are latched at issue; changing them now must not matter.
          operand_a = $urandom;
          operand_b = $urandom;
        end
        @(negedge clock);
        #1;
      end
    end
    check({tag, "_valid"}, 64'(got), 64'd1);
    check({tag, "_stalls"}, 64'(stalls), 64'(exp_stalls));
    check({tag, "_result"}, 64'(md_result), 64'(exp_res));
    check({tag, "_exc"}, 64'(md_exception), 64'(exp_exc));
    check({tag, "_stall_in_done"}, 64'(md_stall), 64'd0);
    // Next instruction enters D/X at the DONE edge.
    dx_ir = mk_ir(5'd0, 5'd0, 5'd0);
    @(negedge clock);
    #1;
    check({tag, "_valid_drop"}, 64'(md_valid), 64'd0);
    check({tag, "_exc_drop"}, 64'(md_exception), 64'd0);
    check({tag, "_hold"}, 64'(md_result), 64'(exp_res));
  endtask

  task automatic check_decode(input logic [31:0] ir, input string tag);
    logic [4:0] opc;
    logic [4:0] op;
    logic       md;
    logic [4:0] exp_alu;
    opc     = ir[31:27];
    op      = ir[6:2];
    md      = (opc == 5'd0) && (op == 5'd6 || op == 5'd7);
    exp_alu = (opc == 5'd0 && !md) ? op
            : (opc == 5'd2 || opc == 5'd6) ? 5'd1 : 5'd0;
    @(negedge clock);
    dx_ir = ir;
    #1;
    check({tag, "_alu_op"}, 64'(alu_op), 64'(exp_alu));
    check({tag, "_shamt"}, 64'(shamt), (opc == 5'd0) ? 64'(ir[11:7]) : 64'd0);
    check({tag, "_sx_sel"}, 64'(sx_sel), 64'(opc != 5'd0));
    check({tag, "_stall"}, 64'(md_stall), 64'(md));
    // Withdraw before the next rising edge so nothing issues.
    #1;
    dx_ir = mk_ir(5'd0, 5'd0, 5'd0);
  endtask

  function automatic logic [31:0] pick_operand();
    logic [31:0] v;
    case ($urandom_range(0, 9))
      0:       v = 32'd0;
      1:       v = 32'hFFFF_FFFF;
      2:       v = 32'h8000_0000;
      3:       v = 32'h7FFF_FFFF;
      4:       v = 32'($urandom_range(0, 20));
      5:       v = -32'($urandom_range(0, 20));
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    // Reset with a mult sitting in D/X: nothing may stall or pulse.
    reset     = 1'b1;
    dx_ir     = mk_ir(5'd0, 5'd6, 5'd0);
    operand_a = 32'd3;
    operand_b = 32'd5;
    #12;
    check("rst_stall", 64'(md_stall), 64'd0);
    check("rst_valid", 64'(md_valid), 64'd0);
    check("rst_exc", 64'(md_exception), 64'd0);
    check("rst_result", 64'(md_result), 64'd0);
    @(negedge clock);
    dx_ir = mk_ir(5'd0, 5'd0, 5'd0);
    reset = 1'b0;
    #1;

    // Directed decode.
    check_decode(mk_ir(5'd0, 5'd3, 5'd9), "dec_op3");
    check_decode(mk_ir(5'd6, 5'd3, 5'd9), "dec_opc6");
    check_decode(mk_ir(5'd2, 5'd17, 5'd4), "dec_opc2");
    check_decode(mk_ir(5'd0, 5'd6, 5'd1), "dec_mult");
    for (int i = 0; i < 6; i++) begin
      check_decode(mk_ir(5'($urandom_range(0, 7)), 5'($urandom), 5'($urandom)),
                   $sformatf("dec_rand%0d", i));
    end
    @(negedge clock);
    #1;

    // Directed mult/div cases.
    run_md(1'b0, 32'd7, -32'd6, "mul_7x-6");
    run_md(1'b0, 32'h4000_0000, 32'd4, "mul_ovf");
    run_md(1'b1, -32'd7, 32'd2, "div_-7/2");
    run_md(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "div_min/-1");
    run_md(1'b1, 32'd5, 32'd0, "div_by0");
    run_md(1'b0, 32'd0, 32'h123, "mul_0x123");
    run_md(1'b0, 32'h8000_0000, 32'd1, "mul_minx1");

    // Reset 10 cycles into a mult.
    dx_ir     = mk_ir(5'd0, 5'd6, 5'd0);
    operand_a = 32'd1234;
    operand_b = 32'd5678;
    repeat (10) @(negedge clock);
    #1;
    check("midrst_busy", 64'(md_stall), 64'd1);
    reset = 1'b1;
    #1;
    check("midrst_stall", 64'(md_stall), 64'd0);
    check("midrst_valid", 64'(md_valid), 64'd0);
    check("midrst_result", 64'(md_result), 64'd0);
    @(negedge clock);
    dx_ir = mk_ir(5'd0, 5'd0, 5'd0);
    reset = 1'b0;
    #1;
    check("postrst_valid", 64'(md_valid), 64'd0);
    run_md(1'b1, 32'd100, 32'd10, "div_100/10");

    // Randomized mult/div against the reference model.
    for (int i = 0; i < 20; i++) begin
      run_md(1'($urandom_range(0, 1)), pick_operand(), pick_operand(),
             $sformatf("rand%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
